// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the multicast crossbar scheduler and its benches.
package crossbar_pkg;

    localparam int unsigned STAT_W  = 32;
    localparam int unsigned SLOT_N  = 8;
    localparam int unsigned SLOT_DW = 32;

    typedef struct packed {
        logic               vld;
        logic [SLOT_N-1:0]  rem;
        logic [SLOT_DW-1:0] data;
    } lane_slot_t;

    // Index width for an N-entry select; returns at least 1 for N >= 2.
    function automatic int unsigned clog2_n(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way combinational round-robin arbiter: searches upward from ptr with wrap.
module rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int unsigned N      = 8,
    parameter int unsigned DW_IDX = clog2_n(N)
) (
    input  logic [N-1:0]      req,
    input  logic [DW_IDX-1:0] ptr,
    output logic [N-1:0]      gnt_c,
    output logic [DW_IDX-1:0] gnt_idx_c
);

    logic              found;
    logic [DW_IDX-1:0] lane;

    // N is a power of two, so the index add wraps naturally.
    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        found     = 1'b0;
        lane      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            lane = ptr + DW_IDX'(i);
            if (!found && req[lane]) begin
                gnt_c[lane] = 1'b1;
                gnt_idx_c   = lane;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossbar_sched.sv
// Per-lane one-entry slots, per-output round-robin grant, idx/data pipeline for the crossbar.
// Optional statistics counters enabled by CROSSBAR_SCHED_STATS_EN.
module crossbar_sched
    import crossbar_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned DW_DATA = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N-1:0]                   in_valid,
    output logic [N-1:0]                   in_ready,
    input  logic [N*DW_DATA-1:0]           in_data,
    input  logic [N*N-1:0]                 in_dst,
    input  logic                           xb_stall,
    output logic [N*clog2_n(N)-1:0]        xb_idx,
    output logic [N*DW_DATA-1:0]           xb_data,
    output logic [N-1:0]                   xb_vld,
    output logic                           busy
`ifdef CROSSBAR_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]              stat_pkts,
    output logic [STAT_W-1:0]              stat_conf
`endif
);

    localparam int unsigned DW_IDX = clog2_n(N);

    logic [N-1:0]                  vld;
    logic [N-1:0][N-1:0]           rem;      // [lane][output]
    logic [N-1:0][DW_DATA-1:0]     data;
    logic [N-1:0][DW_DATA-1:0]     d1;
    logic [N-1:0][DW_IDX-1:0]      ptr;
    logic [N-1:0]                  v1;

    logic [N-1:0][N-1:0]           req;      // [output][lane]
    logic [N-1:0][N-1:0]           gnt;      // [output][lane]
    logic [N-1:0][DW_IDX-1:0]      gnt_idx;
    logic [N-1:0][N-1:0]           served;   // [lane][output]
    logic [N-1:0]                  any_gnt;
    logic [N-1:0]                  pop;
    logic [N-1:0]                  acc;

    // Request matrix; stall masks every request so nothing is granted or served.
    always_comb begin
        req = '0;
        for (int unsigned j = 0; j < N; j++) begin
            for (int unsigned k = 0; k < N; k++) begin
                req[j][k] = vld[k] & rem[k][j] & ~xb_stall;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_arb
        rr_arbiter #(
            .N      (N),
            .DW_IDX (DW_IDX)
        ) u_arb (
            .req       (req[g]),
            .ptr       (ptr[g]),
            .gnt_c     (gnt[g]),
            .gnt_idx_c (gnt_idx[g])
        );
    end

    // Service bookkeeping and same-cycle refill of popping slots.
    always_comb begin
        served   = '0;
        any_gnt  = '0;
        pop      = '0;
        in_ready = '0;
        acc      = '0;
        for (int unsigned j = 0; j < N; j++) begin
            any_gnt[j] = |gnt[j];
            for (int unsigned k = 0; k < N; k++) begin
                served[k][j] = gnt[j][k];
            end
        end
        for (int unsigned k = 0; k < N; k++) begin
            pop[k]      = vld[k] && ((rem[k] & ~served[k]) == '0);
            in_ready[k] = rst_n && (!vld[k] || pop[k]);
            acc[k]      = in_valid[k] && in_ready[k];
        end
    end

    // Lane slots; a zero destination mask is accepted but never occupies the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            rem  <= '0;
            data <= '0;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                if (acc[k]) begin
                    vld[k]  <= |in_dst[k*N +: N];
                    rem[k]  <= in_dst[k*N +: N];
                    data[k] <= in_data[k*DW_DATA +: DW_DATA];
                end else if (pop[k]) begin
                    vld[k] <= 1'b0;
                    rem[k] <= '0;
                end else begin
                    rem[k] <= rem[k] & ~served[k];
                end
            end
        end
    end

    // Pointers plus the two-stage output pipeline matching the crossbar's registered idx.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            v1      <= '0;
            d1      <= '0;
            xb_idx  <= '0;
            xb_vld  <= '0;
            xb_data <= '0;
        end else begin
            for (int unsigned j = 0; j < N; j++) begin
                if (any_gnt[j]) begin
                    ptr[j]                         <= gnt_idx[j] + DW_IDX'(1);
                    xb_idx[j*DW_IDX +: DW_IDX]     <= gnt_idx[j];
                end
            end
            v1      <= any_gnt;
            d1      <= data;
            xb_vld  <= v1;
            xb_data <= d1;
        end
    end

    assign busy = |vld;

`ifdef CROSSBAR_SCHED_STATS_EN
    logic [STAT_W-1:0] n_pop;
    logic              conf;
    logic [STAT_W:0]   pkts_sum;

    always_comb begin
        n_pop = '0;
        conf  = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            n_pop = n_pop + STAT_W'(pop[k]);
        end
        for (int unsigned j = 0; j < N; j++) begin
            if ((req[j] & (req[j] - N'(1))) != '0) conf = 1'b1;
        end
        pkts_sum = {1'b0, stat_pkts} + {1'b0, n_pop};
    end

    // Saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts <= '0;
            stat_conf <= '0;
        end else begin
            stat_pkts <= pkts_sum[STAT_W] ? '1 : pkts_sum[STAT_W-1:0];
            if (conf && (stat_conf != '1)) stat_conf <= stat_conf + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_crossbar_sched.sv
// Directed bench for crossbar_sched at N=4, DW_DATA=8.
module tb_crossbar_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [N*DW-1:0] in_data;
    logic [N*N-1:0]  in_dst;
    logic          xb_stall;
    logic [N*2-1:0]  xb_idx;
    logic [N*DW-1:0] xb_data;
    logic [N-1:0]  xb_vld;
    logic          busy;

    int n_cmp;
    int n_err;

    crossbar_sched #(
        .N       (N),
        .DW_DATA (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_dst   (in_dst),
        .xb_stall (xb_stall),
        .xb_idx   (xb_idx),
        .xb_data  (xb_data),
        .xb_vld   (xb_vld),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic [N*N-1:0] m);
        in_valid = v;
        in_data  = d;
        in_dst   = m;
    endtask

    task automatic pulse_reset();
        in_valid = '0;
        xb_stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_vld", 32'(xb_vld), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_idx", 32'(xb_idx), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        xb_stall = 1'b0;
        drive('0, '0, '0);
        #2;
        check("por_ready", 32'(in_ready), 32'h0);
        check("por_vld", 32'(xb_vld), 32'h0);
        check("por_busy", 32'(busy), 32'h0);
        check("por_idx", 32'(xb_idx), 32'h0);
        check("por_data", 32'(xb_data), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();

        // 1: unicast, no contention
        drive(4'b1111, 32'hA3A2A1A0, 16'h8421);
        check("t1_ready0", 32'(in_ready), 32'hF);
        tick();
        drive('0, '0, '0);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_ready1", 32'(in_ready), 32'hF);
        tick();
        check("t1_idx", 32'(xb_idx), 32'hE4);
        check("t1_vld_early", 32'(xb_vld), 32'h0);
        tick();
        check("t1_vld", 32'(xb_vld), 32'hF);
        check("t1_data", 32'(xb_data), 32'hA3A2A1A0);
        tick();
        check("t1_vld_off", 32'(xb_vld), 32'h0);

        pulse_reset();

        // 2: full contention on output 0
        drive(4'b1111, 32'h13121110, 16'h1111);
        tick();
        drive('0, '0, '0);
        tick();
        check("t2_idx_l0", 32'(xb_idx[1:0]), 32'd0);
        check("t2_vld_e1", 32'(xb_vld), 32'h0);
        tick();
        check("t2_vld_e2", 32'(xb_vld), 32'h1);
        check("t2_idx_l1", 32'(xb_idx[1:0]), 32'd1);
        check("t2_data", 32'(xb_data), 32'h13121110);
        tick();
        check("t2_vld_e3", 32'(xb_vld), 32'h1);
        check("t2_idx_l2", 32'(xb_idx[1:0]), 32'd2);
        tick();
        check("t2_vld_e4", 32'(xb_vld), 32'h1);
        check("t2_idx_l3", 32'(xb_idx[1:0]), 32'd3);
        tick();
        check("t2_vld_e5", 32'(xb_vld), 32'h1);
        check("t2_busy_e5", 32'(busy), 32'h0);
        tick();
        check("t2_vld_e6", 32'(xb_vld), 32'h0);

        // 3: multicast partial service, lane 1 pending with p_1 = 1
        drive(4'b0001, 32'h00000030, 16'h0002);
        tick();
        drive(4'b0011, 32'h00003140, 16'h0023);
        check("t3_ready_refill", 32'(in_ready), 32'hF);
        tick();
        drive('0, '0, '0);
        check("t3_ready_partial", 32'(in_ready), 32'hE);
        tick();
        check("t3_idx_c1", 32'(xb_idx), 32'h04);
        check("t3_vld_c1", 32'(xb_vld), 32'h2);
        check("t3_ready_c2", 32'(in_ready), 32'hF);
        tick();
        check("t3_idx_c2", 32'(xb_idx), 32'h00);
        check("t3_vld_c2", 32'(xb_vld), 32'h3);
        check("t3_data", 32'(xb_data), 32'h13123140);
        check("t3_busy", 32'(busy), 32'h0);
        tick();
        check("t3_vld_c3", 32'(xb_vld), 32'h2);

        // 4: stall with packets pending
        drive(4'b1111, 32'h53525150, 16'h1111);
        check("t4_ready_in", 32'(in_ready), 32'hF);
        tick();
        drive('0, '0, '0);
        tick();
        check("t4_idx_pre", 32'(xb_idx[1:0]), 32'd1);
        xb_stall = 1'b1;
        #1;
        check("t4_ready_stall", 32'(in_ready), 32'h2);
        tick();
        check("t4_vld_s1", 32'(xb_vld), 32'h1);
        check("t4_idx_s1", 32'(xb_idx[1:0]), 32'd1);
        tick();
        check("t4_vld_s2", 32'(xb_vld), 32'h0);
        check("t4_idx_s2", 32'(xb_idx[1:0]), 32'd1);
        tick();
        check("t4_vld_s3", 32'(xb_vld), 32'h0);
        check("t4_idx_s3", 32'(xb_idx[1:0]), 32'd1);
        xb_stall = 1'b0;
        #1;
        check("t4_ready_resume", 32'(in_ready), 32'h6);
        tick();
        check("t4_idx_r1", 32'(xb_idx[1:0]), 32'd2);
        check("t4_vld_r1", 32'(xb_vld), 32'h0);
        tick();
        check("t4_vld_r2", 32'(xb_vld), 32'h1);
        check("t4_idx_r2", 32'(xb_idx[1:0]), 32'd3);
        check("t4_data", 32'(xb_data), 32'h53525150);
        tick();
        check("t4_idx_r3", 32'(xb_idx[1:0]), 32'd0);
        check("t4_vld_r3", 32'(xb_vld), 32'h1);
        tick();
        check("t4_vld_r4", 32'(xb_vld), 32'h1);
        tick();
        check("t4_vld_r5", 32'(xb_vld), 32'h0);
        check("t4_busy", 32'(busy), 32'h0);

        // 5: zero mask dropped, then back-to-back unicast on lane 2
        drive(4'b0100, 32'h00600000, 16'h0000);
        check("t5_ready_a", 32'(in_ready[2]), 32'h1);
        tick();
        check("t5_busy_drop", 32'(busy), 32'h0);
        check("t5_ready_b", 32'(in_ready[2]), 32'h1);
        drive(4'b0100, 32'h00610000, 16'h0400);
        tick();
        drive('0, '0, '0);
        check("t5_busy", 32'(busy), 32'h1);
        check("t5_ready_c", 32'(in_ready[2]), 32'h1);
        check("t5_vld_drop", 32'(xb_vld), 32'h0);
        tick();
        check("t5_idx", 32'(xb_idx), 32'h20);
        check("t5_vld_e2", 32'(xb_vld), 32'h0);
        tick();
        check("t5_vld", 32'(xb_vld), 32'h4);
        check("t5_data", 32'(xb_data[23:16]), 32'h61);

        // 6: async reset mid-flight with three slots pending
        drive(4'b1011, 32'h73007170, 16'hC0CC);
        tick();
        drive('0, '0, '0);
        tick();
        check("t6_busy_pre", 32'(busy), 32'h1);
        check("t6_idx_pre", 32'(xb_idx), 32'h30);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_vld_rst", 32'(xb_vld), 32'h0);
        check("t6_busy_rst", 32'(busy), 32'h0);
        check("t6_idx_rst", 32'(xb_idx), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        check("t6_vld_post1", 32'(xb_vld), 32'h0);
        tick();
        check("t6_vld_post2", 32'(xb_vld), 32'h0);
        check("t6_busy_post", 32'(busy), 32'h0);
        drive(4'b0011, 32'h00008180, 16'h0011);
        tick();
        drive('0, '0, '0);
        tick();
        check("t6_idx_n1", 32'(xb_idx[1:0]), 32'd0);
        tick();
        check("t6_idx_n2", 32'(xb_idx[1:0]), 32'd1);
        check("t6_vld_n2", 32'(xb_vld), 32'h1);
        check("t6_data_n2", 32'(xb_data[7:0]), 32'h80);
        tick();
        check("t6_vld_n3", 32'(xb_vld), 32'h1);
        tick();
        check("t6_vld_n4", 32'(xb_vld), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/crossbar_sched.md
Name: crossbar_sched

Overview:
- Upstream scheduler for the N-to-N multicast crossbar.
- Accepts one packet per input lane, each with an N-bit destination mask, and buffers it in a one-entry slot per lane.
- Each cycle, every output independently picks one requesting lane by round-robin. It then drives the crossbar's per-output source index, followed by the data one cycle later, to match the crossbar's registered control.
- A lane retires once every destination in its mask has been served, possibly over several cycles (partial multicast service).

Parameters:
- N, 8, number of input lanes and output ports (power of two, 2..32).
- DW_DATA, 32, payload width per lane.
- DW_IDX, $clog2(N), source-index width; derived, do not override.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-lane packet valid.
- in_ready  output  N  per-lane accept; a transfer occurs when valid and ready are both high.
- in_data  input  N*DW_DATA  per-lane payload; lane k at [k*DW_DATA +: DW_DATA].
- in_dst  input  N*N  per-lane destination mask; lane k at [k*N +: N], bit j = output j.
- xb_stall  input  1  downstream hold; no grants are issued while high.
- xb_idx  output  N*DW_IDX  per-output source lane, fed to the crossbar idx port.
- xb_data  output  N*DW_DATA  per-lane payload, fed to the crossbar in port; aligned one cycle after xb_idx.
- xb_vld  output  N  per-output valid; aligned with xb_data and the crossbar output.
- busy  output  1  OR of all lane slot-valid bits.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous, active-low (rst_n).
- Values under reset:
  - All slot-valid bits, remaining masks and xb_vld are 0.
  - xb_idx and xb_data are 0.
  - Every round-robin pointer is 0.
  - in_ready is 0 while rst_n is low.
- Lane slot: each lane holds {vld, data, rem[N-1:0]}.
  - in_ready[k] = !vld[k] || pop[k], combinational through the grant logic.
  - On accept: data is stored and rem = in_dst.
  - A zero mask is accepted and dropped; the slot stays empty.
- Grant, evaluated every cycle with xb_stall = 0:
  - For output j, req_j[k] = vld[k] & rem[k][j].
  - The round-robin arbiter for j returns a one-hot gnt_j, searching from pointer p_j upward with wrap.
  - If gnt_j is non-zero, p_j <= (granted lane + 1) mod N. Otherwise p_j holds.
- Service:
  - rem[k][j] is cleared for each output j that granted lane k.
  - pop[k] = vld[k] && (rem[k] & ~served[k]) == 0.
  - A popped slot may accept a new packet in the same cycle.
- Output pipeline:
  - Edge t (grant edge): xb_idx[j] <= encoded gnt_j when granted, else it holds its previous value. A stage-1 valid register v1[j] <= |gnt_j.
  - Edge t+1: xb_data[k] <= the data registered for lane k at edge t, and xb_vld <= v1.
  - Latency: from accept to first xb_vld is 3 edges minimum (slot, idx, data).
- Stall:
  - xb_stall = 1 means no grants and no rem changes.
  - v1 is 0 for that cycle, so xb_vld drops to 0 one cycle later. xb_idx holds.
  - The pointers hold.
  - Accepts continue into empty slots only.
- Simultaneous events: several outputs granting the same lane in one cycle is legal multicast. All served bits are cleared together.
- Reset mid-operation: pending packets are lost. Outputs clear asynchronously; no xb_vld may glitch high after reset deassertion.
- Ordering: per lane, packets are strictly in order. There is no ordering guarantee across lanes.
- Fairness: each requesting lane is served by output j within N grant cycles of that output.

Optional Feature:
- Macro: CROSSBAR_SCHED_STATS_EN.
- When defined, two extra ports are added:
  - stat_pkts (output, 32): saturating count of retired packets (pops with a non-zero mask).
  - stat_conf (output, 32): saturating count of cycles in which any output had more than one requester.
  - Both counters reset to 0 and hold at 32'hFFFF_FFFF.
- When undefined, the ports and counters are absent; the core behaviour is identical.

Decomposition:
- Package crossbar_pkg holds:
  - function clog2_n(N) for DW_IDX;
  - localparam STAT_W = 32;
  - a lane-slot typedef {vld, rem, data}, shared with the crossbar testbench.
- Sub-module rr_arbiter (N-way, pointer input, one-hot grant output, combinational), instantiated N times.
- The pointer registers stay in crossbar_sched.

Test Plan (N=4, DW_DATA=8):
1. Unicast, no contention:
   - Stimulus: lanes 0..3 carry data 0xA0..0xA3, masks 0001, 0010, 0100, 1000, in one cycle.
   - Required: xb_idx = {3,2,1,0} one edge later, and xb_vld = 1111 with each output carrying its lane's data one edge after that. All four in_ready are high again on the next cycle.
2. Full contention:
   - Stimulus: all lanes target mask 0001, data 0x10..0x13.
   - Required: output 0 serves lanes 0, 1, 2, 3 in consecutive cycles. xb_vld = 0001 for 4 cycles, then 0. p_0 wraps back to 0.
3. Multicast partial service:
   - Stimulus: lane 0 has mask 0011. Lane 1 has mask 0010 and is already pending, with p_1 = 1.
   - Required: cycle 1 grants out0 <- lane 0 and out1 <- lane 1, so lane 0 has rem = 0010. Cycle 2 grants out1 <- lane 0, and lane 0 pops.
4. Stall:
   - Stimulus: assert xb_stall for 3 cycles with packets pending.
   - Required: xb_vld is 0 from one cycle after assertion. xb_idx, rem and the pointers are frozen. Service resumes exactly where it stopped.
5. Zero mask and back-to-back:
   - Stimulus: lane 2 sends mask 0000, then mask 0100 on the next cycle.
   - Required: the first packet is dropped with no xb_vld. The second is delivered on output 2, and in_ready[2] stays high throughout.
6. Async reset mid-flight:
   - Stimulus: pull rst_n low between clock edges with 3 slots pending.
   - Required: xb_vld = 0 and busy = 0 immediately. After release, the first new packet is delivered with the pointers starting at 0.
